uart_sync_fifo_p: RTL and testbench
===================================

# uart_sync_fifo_p

Parametrised single-clock FIFO for the CoreUARTapb TX and RX data paths, replacing the fixed 128x8 controller. Width, depth and threshold are generics. The block uses its full depth, so a DEPTH-entry FIFO holds DEPTH words. It adds an occupancy output, a programmable almost-empty threshold and sticky overflow/underflow error flags.

## Interface
- DATA_W, 8, data width in bits
- DEPTH, 256, number of entries; any value ≥2 (need not be a power of two)
- CNT_W, $clog2(DEPTH+1), occupancy/threshold width (derived; not overridden)
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- data_in  in  DATA_W  write data
- write_n  in  1  write request, active low
- read_n  in  1  read request, active low
- level_hi  in  CNT_W  almost-full threshold
- level_lo  in  CNT_W  almost-empty threshold
- clr_err  in  1  clears sticky error flags, active high
- data_out  out  DATA_W  registered read data
- count  out  CNT_W  current occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- half  out  1  count ≥ level_hi
- low  out  1  count ≤ level_lo
- overflow  out  1  sticky: a write was attempted while full with no read
- underflow  out  1  sticky: a read was attempted while empty

## Operation
- Write accepted: write_n=0 and (not full, or read accepted in the same cycle). Read accepted: read_n=0 and not empty.
- Accepted write: the word is stored at wr_ptr, and wr_ptr advances, wrapping from DEPTH-1 to 0.
- Accepted read: data_out loads mem[rd_ptr], and rd_ptr advances with the same wrap rule.
- count changes by +1 for a write only, −1 for a read only, and 0 for both or neither.
- Simultaneous read and write when full: both are accepted. The outgoing word is the oldest word, never the incoming one.
- Simultaneous read and write when empty: only the write is accepted. underflow sets.
- Rejected write (full, no read): data is dropped, pointers and count are unchanged, and overflow sets.
- Rejected read (empty): data_out holds, and underflow sets.
- data_out holds its value on every cycle without an accepted read.
- clr_err=1 clears both error flags at the next edge. If an error event occurs in the same cycle, set wins.
- full, empty, half and low are combinational decodes of the registered count.

## Timing
- Reset (asynchronous assert, synchronous release) gives:
  - pointers, count, data_out, overflow and underflow all 0
  - empty=1, full=0
  - low=1 when level_lo ≥ 0 (always); half=(level_hi==0)
- Write latency: a word written at edge N is readable by a read request in cycle N+1. empty deasserts after edge N.
- Read latency: a read sampled at edge N presents its data on data_out after edge N, valid from cycle N+1.
- Flags follow count with zero added latency. No flag is registered separately.
- Reset asserted mid-operation discards all contents immediately. Storage contents are not cleared but are unreachable.

## Configuration
- UART_FIFO_ERR_FLAGS_EN defined: overflow and underflow behave as specified, and the clr_err logic is built.
- Not defined: overflow and underflow are tied to 0 and clr_err is ignored.
- The not-defined case has no other behaviour differences: rejected accesses are still dropped or held.

## Structure
- Package uart_fifo_pkg holds:
  - the default DATA_W and DEPTH constants
  - a ptr_inc function (increment with wrap at DEPTH-1)
- Sub-module uart_fifo_mem is a DEPTH x DATA_W register/RAM array with a synchronous write port and an asynchronous read port. It is instantiated once.
- The controller (pointers, count, flags, output register) stays in the top module.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 and read 3 times:
  - data_out is 0x11, 0x22, 0x33 on consecutive cycles
  - count goes 3→0 and empty returns to 1
- DEPTH=5, 5 writes: full=1 and count=5. A 6th write is dropped, overflow=1, and count stays 5.
- Full FIFO, simultaneous read and write: count stays at DEPTH, data_out is the oldest word, and the new word is read last.
- Read while empty: underflow=1 and data_out unchanged. clr_err pulse gives underflow=0 next cycle.
- level_hi=4, level_lo=1, fill 0→5:
  - low=1 at counts 0–1, 0 afterwards
  - half=1 from count 4
- DEPTH=5, 12 writes interleaved with reads: pointers wrap without data corruption. Mid-run reset gives count=0, empty=1 and data_out=0 immediately.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared defaults and pointer helper for the parametrised UART FIFO.
package uart_fifo_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 256;

    // Increment a storage pointer, wrapping from depth-1 back to 0 (depth need not be 2^n).
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x DATA_W storage, synchronous write port, asynchronous read port.
module uart_fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Store the incoming word on an accepted write; contents are never reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_sync_fifo_p.sv
// uart_sync_fifo_p: parametrised single-clock FIFO for the UART TX/RX paths.
// Full-depth occupancy counter, programmable thresholds, registered read data.
// Optional macro UART_FIFO_ERR_FLAGS_EN builds the sticky overflow/underflow
// flags and their clr_err clear; otherwise both flags are tied low.
module uart_sync_fifo_p
    import uart_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write_n,
    input  logic              read_n,
    input  logic [CNT_W-1:0]  level_hi,
    input  logic [CNT_W-1:0]  level_lo,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              half,
    output logic              low,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] rd_word;
    logic              wr_acc;
    logic              rd_acc;

    // Flags are pure decodes of the registered count.
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign half  = (count >= level_hi);
    assign low   = (count <= level_lo);

    // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
    assign rd_acc = ~read_n & ~empty;
    assign wr_acc = ~write_n & (~full | rd_acc);

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clock (clock),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    // Advance pointers on accepted accesses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), DEPTH));
            end
            if (rd_acc) begin
                rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), DEPTH));
            end
        end
    end

    // Occupancy: +1 write only, -1 read only, unchanged for both or neither.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Output register loads the oldest word on an accepted read and holds otherwise.
    // The async read port sees the pre-edge contents, so a full read+write returns the old word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
        end else if (rd_acc) begin
            data_out <= rd_word;
        end
    end

`ifdef UART_FIFO_ERR_FLAGS_EN
    logic ovf_evt;
    logic udf_evt;

    assign ovf_evt = ~write_n & full & ~rd_acc;
    assign udf_evt = ~read_n & empty;

    // Sticky error flags; a new event in the clearing cycle wins over clr_err.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  & ~clr_err) | ovf_evt;
            underflow <= (underflow & ~clr_err) | udf_evt;
        end
    end
`else
    logic unused_clr_err;

    assign unused_clr_err = clr_err;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_sync_fifo_p.sv
// tb_uart_sync_fifo_p: randomized + directed scoreboard bench for uart_sync_fifo_p (DEPTH=5).
module tb_uart_sync_fifo_p;

    localparam int unsigned DW = 8;
    localparam int unsigned DP = 5;
    localparam int unsigned CW = $clog2(DP + 1);

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          write_n = 1'b1;
    logic          read_n = 1'b1;
    logic [CW-1:0] level_hi = '0;
    logic [CW-1:0] level_lo = '0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] data_out;
    logic [CW-1:0] count;
    logic          full, empty, half, low, overflow, underflow;

    uart_sync_fifo_p #(
        .DATA_W (DW),
        .DEPTH  (DP)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .write_n   (write_n),
        .read_n    (read_n),
        .level_hi  (level_hi),
        .level_lo  (level_lo),
        .clr_err   (clr_err),
        .data_out  (data_out),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .half      (half),
        .low       (low),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        int dout;
        int cnt;
        int fl;
        int em;
        int hf;
        int lw;
        int ovf;
        int udf;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: a plain queue of words plus output/error state.
    int mq[$];
    int m_dout = 0;
    int m_ovf = 0;
    int m_udf = 0;

    int n_tests = 0;
    int n_fail = 0;

`ifdef UART_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t snapshot(input int lh, input int ll);
        exp_t e;
        e.dout = m_dout;
        e.cnt  = mq.size();
        e.fl   = (mq.size() == DP) ? 1 : 0;
        e.em   = (mq.size() == 0) ? 1 : 0;
        e.hf   = (mq.size() >= lh) ? 1 : 0;
        e.lw   = (mq.size() <= ll) ? 1 : 0;
        e.ovf  = m_ovf;
        e.udf  = m_udf;
        return e;
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue the expected post-edge state.
    task automatic step(input bit we, input bit re, input int d, input bit clr,
                        input int lh, input int ll);
        bit rd_ok, wr_ok, ovf_ev, udf_ev;
        @(negedge clock);
        write_n  = ~we;
        read_n   = ~re;
        data_in  = DW'(d);
        clr_err  = clr;
        level_hi = CW'(lh);
        level_lo = CW'(ll);
        rd_ok  = re && (mq.size() > 0);
        wr_ok  = we && ((mq.size() < DP) || rd_ok);
        ovf_ev = we && !wr_ok;
        udf_ev = re && (mq.size() == 0);
        if (rd_ok) m_dout = mq.pop_front();
        if (wr_ok) mq.push_back(d & 8'hff);
        if (ERR_EN) begin
            if (clr) begin
                m_ovf = 0;
                m_udf = 0;
            end
            if (ovf_ev) m_ovf = 1;
            if (udf_ev) m_udf = 1;
        end
        exp_q.push_back(snapshot(lh, ll));
    endtask

    task automatic check_now(input string tag, input int lh, input int ll);
        exp_t e;
        e = snapshot(lh, ll);
        chk({tag, "_dout"},  int'(data_out), e.dout);
        chk({tag, "_count"}, int'(count),    e.cnt);
        chk({tag, "_full"},  int'(full),     e.fl);
        chk({tag, "_empty"}, int'(empty),    e.em);
        chk({tag, "_half"},  int'(half),     e.hf);
        chk({tag, "_low"},   int'(low),      e.lw);
        chk({tag, "_ovf"},   int'(overflow), e.ovf);
        chk({tag, "_udf"},   int'(underflow), e.udf);
    endtask

    // Apply reset at a falling edge; the discard must be visible immediately.
    task automatic do_reset(input string tag);
        @(negedge clock);
        write_n = 1'b1;
        read_n  = 1'b1;
        clr_err = 1'b0;
        reset_n = 1'b0;
        mq.delete();
        m_dout = 0;
        m_ovf = 0;
        m_udf = 0;
        #1;
        check_now(tag, int'(level_hi), int'(level_lo));
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Monitor: after every rising edge, compare the DUT against the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("data_out",  int'(data_out),  e.dout);
                chk("count",     int'(count),     e.cnt);
                chk("full",      int'(full),      e.fl);
                chk("empty",     int'(empty),     e.em);
                chk("half",      int'(half),      e.hf);
                chk("low",       int'(low),       e.lw);
                chk("overflow",  int'(overflow),  e.ovf);
                chk("underflow", int'(underflow), e.udf);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lh, ll;
        // Reset state with level_hi=0 so half must read 1.
        #3;
        check_now("reset", 0, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Basic order: three writes then three reads.
        step(1, 0, 8'h11, 0, 4, 1);
        step(1, 0, 8'h22, 0, 4, 1);
        step(1, 0, 8'h33, 0, 4, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 4, 1);

        // Fill 0->5 (threshold sweep), then a dropped sixth write.
        for (int i = 0; i < 5; i++) step(1, 0, 8'hA0 + i, 0, 4, 1);
        step(1, 0, 8'hEE, 0, 4, 1);
        step(0, 0, 0, 0, 4, 1);

        // Full: simultaneous read and write keeps count, returns oldest.
        step(1, 1, 8'h5C, 0, 4, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 4, 1);

        // Read while empty, then clear pulse; clear and overflow event together.
        step(0, 1, 0, 0, 4, 1);
        step(0, 0, 0, 1, 4, 1);
        step(0, 0, 0, 0, 4, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 8'h60 + i, 0, 4, 1);
        step(1, 0, 8'h77, 1, 4, 1);
        step(0, 0, 0, 1, 4, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 4, 1);

        // Wrap exercise: 12 writes interleaved with reads.
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 8'hC0 + i, 0, 4, 1);
            if (i % 2 == 1) step(0, 1, 0, 0, 4, 1);
        end
        do_reset("midreset");

        // Randomized traffic around a second mid-run reset.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 250; i++) begin
                lh = int'($urandom_range(0, 7));
                ll = int'($urandom_range(0, 7));
                step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                     int'($urandom_range(0, 255)), $urandom_range(0, 99) < 6, lh, ll);
            end
            if (r == 0) do_reset("randreset");
        end
        step(0, 0, 0, 0, 4, 1);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
